// File: rtl/atc_uart_rx.sv
// atc_uart_rx -- 8N1 UART receiver for the ATC command decoder.
//
// Samples the asynchronous rx line through a two-flop synchronizer. Each
// LSB-first byte is rebuilt from samples taken at the middle of each bit
// cell. The byte is then offered on a valid/ready interface.
//
// Optional build macro:
//   ATC_UART_RX_PARITY_EN  -- expects an even-parity bit between bit 7 and
//                             the stop bit. Default (undefined) is plain 8N1.
//
// Ports:
//   clock          system clock
//   reset          synchronous, active-high reset
//   rx             asynchronous serial line, idles high
//   data[7:0]      received byte, meaningful only while valid=1
//   valid          byte available
//   ready          consumer accepts the byte (transfer on valid && ready)
//   framing_error  level: the last completed frame was bad
//   overrun        one-cycle pulse: a completed byte was dropped
//   receiving      high while a frame is in progress (START/DATA/PARITY/STOP)
module atc_uart_rx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_error,
  output logic       overrun,
  output logic       receiving
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

`ifdef ATC_UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t           state_q, state_d;
  logic             sync1, rx_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             good_frame, bad_frame;
  logic             parity_ok;

`ifdef ATC_UART_RX_PARITY_EN
  logic parity_ok_q, parity_ok_d;
  assign parity_ok = parity_ok_q;
`else
  assign parity_ok = 1'b1;
`endif

  // Next-state logic. The cycle counter is 0 in the first cycle of each state.
  // A state samples rx_s when the counter reaches its last value, so the
  // samples land in mid-cell.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    receiving  = 1'b0;
`ifdef ATC_UART_RX_PARITY_EN
    parity_ok_d = parity_ok_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        receiving = 1'b1;
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          // A start bit that is already gone by mid-cell is a glitch.
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        receiving = 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef ATC_UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef ATC_UART_RX_PARITY_EN
      PARITY: begin
        receiving = 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d       = '0;
          // Even parity: data bits plus parity bit carry an even number of ones.
          parity_ok_d = ~(^{shift_q, rx_s});
          state_d     = STOP;
        end
      end
`endif
      STOP: begin
        receiving = 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s && parity_ok) begin
            good_frame = 1'b1;
            state_d    = IDLE;
          end else begin
            bad_frame = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        // Wait for the line to recover so a held-low line is not taken as a start.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
`ifdef ATC_UART_RX_PARITY_EN
      parity_ok_q <= 1'b1;
`endif
    end else begin
      sync1   <= rx;
      rx_s    <= sync1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef ATC_UART_RX_PARITY_EN
      parity_ok_q <= parity_ok_d;
`endif
    end
  end

  // Output handshake. A completing frame may refill the holding register
  // in the same edge that the consumer drains it.
  always_ff @(posedge clock) begin
    if (reset) begin
      data          <= 8'h00;
      valid         <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (good_frame) begin
        framing_error <= 1'b0;
        if (!valid || ready) begin
          data  <= shift_q;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (bad_frame) framing_error <= 1'b1;
    end
  end

endmodule
